// File: rtl/io_cmd_tx.sv
// Host-side byte-serial BLAKE2 command transmitter: config bytes, then START/DATA/LAST blocks.
// Optional abort input is compiled in when IO_TX_ABORT_EN is defined.
module io_cmd_tx #(
    parameter int READY_GAP = 2
) (
    input  logic        clk,
    input  logic        nreset,
`ifdef IO_TX_ABORT_EN
    input  logic        abort_i,
`endif
    input  logic        cfg_v_i,
    input  logic [5:0]  kk_i,
    input  logic [5:0]  nn_i,
    input  logic [63:0] ll_i,
    output logic        cfg_ready_o,
    input  logic        s_valid_i,
    input  logic [7:0]  s_data_i,
    output logic        s_ready_o,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [1:0]  cmd_o,
    output logic [7:0]  data_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [1:0] CMD_CONF  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_DATA  = 2'd2;
    localparam logic [1:0] CMD_LAST  = 2'd3;
    localparam int GW = (READY_GAP > 1) ? $clog2(READY_GAP) : 1;

    typedef enum logic [2:0] {IDLE, CONF, WAIT_RDY, KEY, MSG, GAP, DONE} state_t;

    state_t       state, n_state;
    logic [5:0]   kk, n_kk, nn, n_nn, idx, n_idx;
    logic [63:0]  ll, n_ll, rem, n_rem;
    logic [57:0]  blk, n_blk, last_blk, n_last_blk;
    logic [3:0]   cidx, n_cidx;
    logic [GW-1:0] gap_cnt, n_gap_cnt;
    logic         pull, n_pull, n_valid, n_done;
    logic [1:0]   n_cmd;
    logic [7:0]   n_data;

    // Index of the final block: B-1, where B counts the key block plus message blocks (at least one).
    function automatic logic [57:0] last_block(input logic [5:0] k, input logic [63:0] l);
        logic [58:0] c;
        c = 59'(l[63:6]) + 59'(l[5:0] != 6'd0);
        if (k != 6'd0)
            return c[57:0];
        else if (c == 59'd0)
            return 58'd0;
        else
            return 58'(c - 59'd1);
    endfunction

    function automatic logic [7:0] conf_byte(input logic [3:0] i, input logic [5:0] k,
                                             input logic [5:0] n, input logic [63:0] l);
        logic [63:0] sh;
        sh = l >> {i - 4'd2, 3'b000};
        case (i)
            4'd0:    return {2'b00, k};
            4'd1:    return {2'b00, n};
            default: return sh[7:0];
        endcase
    endfunction

    // A single-block job tags bytes after the first as LAST so the receiver sees first and last together.
    function automatic logic [1:0] block_tag(input logic [57:0] b, input logic [57:0] lb,
                                             input logic [5:0] i);
        if (b == 58'd0)
            return (i == 6'd0 || lb != 58'd0) ? CMD_START : CMD_LAST;
        else if (b == lb)
            return CMD_LAST;
        else
            return CMD_DATA;
    endfunction

    always_comb begin
        n_state    = state;
        n_kk       = kk;
        n_nn       = nn;
        n_ll       = ll;
        n_rem      = rem;
        n_blk      = blk;
        n_last_blk = last_blk;
        n_idx      = idx;
        n_cidx     = cidx;
        n_gap_cnt  = gap_cnt;
        n_valid    = 1'b0;
        n_cmd      = CMD_CONF;
        n_data     = 8'd0;
        n_done     = 1'b0;
        pull       = (state == KEY && idx < kk) || (state == MSG && rem != 64'd0);

        case (state)
            IDLE: begin
                if (cfg_v_i) begin
                    n_kk       = kk_i;
                    n_nn       = nn_i;
                    n_ll       = ll_i;
                    n_rem      = ll_i;
                    n_blk      = 58'd0;
                    n_last_blk = last_block(kk_i, ll_i);
                    n_cidx     = 4'd0;
                    n_state    = CONF;
                end
            end
            CONF: begin
                n_valid = 1'b1;
                n_cmd   = CMD_CONF;
                n_data  = conf_byte(cidx, kk, nn, ll);
                n_cidx  = cidx + 4'd1;
                if (cidx == 4'd9)
                    n_state = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (ready_i) begin
                    n_idx   = 6'd0;
                    n_state = (blk == 58'd0 && kk != 6'd0) ? KEY : MSG;
                end
            end
            KEY, MSG: begin
                // While pulling, an empty upstream cycle is a gap: nothing emitted, idx held.
                if (!pull || s_valid_i) begin
                    n_valid = 1'b1;
                    n_cmd   = block_tag(blk, last_blk, idx);
                    n_data  = pull ? s_data_i : 8'd0;
                    if (state == MSG && pull)
                        n_rem = rem - 64'd1;
                    n_idx = idx + 6'd1;
                    if (idx == 6'd63) begin
                        if (blk == last_blk) begin
                            n_state = DONE;
                        end else begin
                            n_blk     = blk + 58'd1;
                            n_gap_cnt = '0;
                            n_state   = (READY_GAP == 0) ? WAIT_RDY : GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GW'(READY_GAP - 1))
                    n_state = WAIT_RDY;
                else
                    n_gap_cnt = gap_cnt + GW'(1);
            end
            DONE: begin
                n_done  = 1'b1;
                n_state = IDLE;
            end
            default: n_state = IDLE;
        endcase

`ifdef IO_TX_ABORT_EN
        if (abort_i && state != IDLE) begin
            n_state = IDLE;
            n_valid = 1'b0;
            n_cmd   = CMD_CONF;
            n_data  = 8'd0;
            n_done  = 1'b0;
        end
`endif

        // s_ready_o is registered, so it advertises the pull decision of the coming cycle.
        n_pull = (n_state == KEY && n_idx < n_kk) || (n_state == MSG && n_rem != 64'd0);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= IDLE;
            valid_o     <= 1'b0;
            cmd_o       <= CMD_CONF;
            data_o      <= 8'd0;
            s_ready_o   <= 1'b0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            cfg_ready_o <= 1'b1;
        end else begin
            state       <= n_state;
            valid_o     <= n_valid;
            cmd_o       <= n_cmd;
            data_o      <= n_data;
            s_ready_o   <= n_pull;
            done_o      <= n_done;
            busy_o      <= (n_state != IDLE);
            cfg_ready_o <= (n_state == IDLE);
        end
    end

    always_ff @(posedge clk) begin
        kk       <= n_kk;
        nn       <= n_nn;
        ll       <= n_ll;
        rem      <= n_rem;
        blk      <= n_blk;
        last_blk <= n_last_blk;
        idx      <= n_idx;
        cidx     <= n_cidx;
        gap_cnt  <= n_gap_cnt;
    end

endmodule

// File: tb/tb_io_cmd_tx.sv
// Directed table-driven bench for io_cmd_tx: per-job tag counts, byte sums, config bytes, done timing.
module tb_io_cmd_tx;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cfg_v_i = 1'b0;
    logic [5:0]  kk_i = '0;
    logic [5:0]  nn_i = '0;
    logic [63:0] ll_i = '0;
    logic        cfg_ready_o;
    logic        s_valid_i = 1'b0;
    logic [7:0]  s_data_i = '0;
    logic        s_ready_o;
    logic        ready_i = 1'b0;
    logic        valid_o;
    logic [1:0]  cmd_o;
    logic [7:0]  data_o;
    logic        busy_o;
    logic        done_o;
`ifdef IO_TX_ABORT_EN
    logic        abort_i = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    io_cmd_tx #(.READY_GAP(2)) dut (
        .clk(clk),
        .nreset(nreset),
`ifdef IO_TX_ABORT_EN
        .abort_i(abort_i),
`endif
        .cfg_v_i(cfg_v_i),
        .kk_i(kk_i),
        .nn_i(nn_i),
        .ll_i(ll_i),
        .cfg_ready_o(cfg_ready_o),
        .s_valid_i(s_valid_i),
        .s_data_i(s_data_i),
        .s_ready_o(s_ready_o),
        .ready_i(ready_i),
        .valid_o(valid_o),
        .cmd_o(cmd_o),
        .data_o(data_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    // Upstream byte j of a job is 8'h61 + j; sums below are of emitted block bytes (pads are zero).
    typedef struct {
        logic [5:0]  kk;
        logic [5:0]  nn;
        logic [63:0] ll;
        int          start_n;
        int          data_n;
        int          last_n;
        logic [15:0] sum;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // cut: 0 run to completion, 1 reset at block 1 idx 20, 2 abort at the same point.
    task automatic run_job(input int t, input bit toggle, input int hold, input int cut);
        vec_t v;
        int conf_n = 0;
        logic [79:0] conf = '0;
        int st = 0, da = 0, la = 0, acc = 0, bb = 0, dones = 0, cyc = 0;
        int conf_done = -1, rise = -1, lat = -1, exp_bytes;
        logic [15:0] sum = '0;
        bit expect_done = 0, done_ok = 0, finished = 0, hold_bad = 0, cut_hit = 0, accept;
        logic [1:0] first_tag = 2'd0;
        v = tbl[t];
        exp_bytes = v.start_n + v.data_n + v.last_n;

        @(posedge clk); #1;
        kk_i = v.kk; nn_i = v.nn; ll_i = v.ll; cfg_v_i = 1'b1;
        ready_i = (hold == 0);
        s_valid_i = 1'b1; s_data_i = 8'h61;
        @(posedge clk); #1;
        cfg_v_i = 1'b0;

        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (expect_done) begin
                done_ok = done_o && cfg_ready_o && !busy_o;
                expect_done = 0;
                finished = 1;
            end
            if (done_o) dones++;
            if (valid_o) begin
                if (cmd_o == 2'd0) begin
                    if (conf_n < 10) conf[conf_n*8 +: 8] = data_o;
                    conf_n++;
                    if (conf_n == 10) conf_done = cyc;
                end else begin
                    if (hold > 0 && !ready_i) hold_bad = 1;
                    if (bb == 0) begin
                        lat = cyc - rise;
                        first_tag = cmd_o;
                    end
                    case (cmd_o)
                        2'd1: st++;
                        2'd2: da++;
                        default: la++;
                    endcase
                    sum = sum + 16'(data_o);
                    bb++;
                    if (bb == exp_bytes) expect_done = 1;
                end
            end
            if (cut != 0 && bb == 84) begin
                cut_hit = 1;
                break;
            end
            accept = s_valid_i && s_ready_o;
            @(posedge clk);
            if (accept) acc++;
            #1;
            s_data_i = 8'h61 + 8'(acc);
            s_valid_i = toggle ? ~s_valid_i : 1'b1;
            cfg_v_i = toggle && (cyc == 40);
            if (toggle && cyc == 40) kk_i = 6'd9;
            if (hold > 0) begin
                if (!ready_i && conf_done >= 0 && cyc - conf_done >= hold) begin
                    ready_i = 1'b1;
                    rise = cyc;
                end
            end else begin
                ready_i = !(toggle && bb >= 66 && bb < 100);
            end
        end
        cfg_v_i = 1'b0;

        if (cut != 0) begin
            check("cut_reached", cut_hit, 1);
            @(posedge clk); #1;
            if (cut == 1) nreset = 1'b0;
`ifdef IO_TX_ABORT_EN
            if (cut == 2) abort_i = 1'b1;
`endif
            @(posedge clk); #1;
            nreset = 1'b1;
`ifdef IO_TX_ABORT_EN
            abort_i = 1'b0;
`endif
            s_valid_i = 1'b0;
            @(negedge clk);
            check("cut_valid", valid_o, 0);
            check("cut_cfg_ready", cfg_ready_o, 1);
            check("cut_busy", busy_o, 0);
            check("cut_s_ready", s_ready_o, 0);
            hold_bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (valid_o || done_o) hold_bad = 1;
            end
            check("cut_quiet", hold_bad, 0);
            return;
        end

        s_valid_i = 1'b0;
        check("finished", finished, 1);
        check("conf_count", conf_n, 10);
        check("conf_bytes", conf, {v.ll, 2'b00, v.nn, 2'b00, v.kk});
        check("start_count", st, v.start_n);
        check("data_count", da, v.data_n);
        check("last_count", la, v.last_n);
        check("byte_sum", sum, v.sum);
        check("accepted", acc, int'(v.kk) + int'(v.ll));
        check("done_timing", done_ok, 1);
        @(negedge clk);
        if (done_o) dones++;
        check("done_once", dones, 1);
        if (hold > 0) begin
            check("hold_quiet", hold_bad, 0);
            check("ready_latency_ok", (lat >= 1 && lat <= 3), 1);
            check("first_tag", first_tag, 2'd1);
        end
    endtask

    initial begin
        tbl[0] = '{6'd0,  6'd32, 64'd3,   1,  0,   63, 16'd294};
        tbl[1] = '{6'd0,  6'd32, 64'd0,   1,  0,   63, 16'd0};
        tbl[2] = '{6'd2,  6'd16, 64'd65,  64, 64,  64, 16'd8710};
        tbl[3] = '{6'd0,  6'd8,  64'd64,  1,  0,   63, 16'd8224};
        tbl[4] = '{6'd0,  6'd1,  64'd128, 64, 0,   64, 16'd20544};
        tbl[5] = '{6'd5,  6'd20, 64'd0,   1,  0,   63, 16'd495};
        tbl[6] = '{6'd32, 6'd32, 64'd130, 64, 128, 64, 16'd27987};

        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_cmd", cmd_o, 0);
        check("rst_data", data_o, 0);
        check("rst_s_ready", s_ready_o, 0);
        check("rst_done", done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_cfg_ready", cfg_ready_o, 1);

        for (int t = 0; t < 7; t++)
            run_job(t, 1'b0, 0, 0);

        run_job(2, 1'b0, 50, 0);
        run_job(2, 1'b1, 0, 0);
        run_job(2, 1'b0, 0, 1);
        run_job(0, 1'b0, 0, 0);
`ifdef IO_TX_ABORT_EN
        run_job(2, 1'b0, 0, 2);
        run_job(0, 1'b0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
